// File: rtl/calc_pkg.sv
// Key codes shared by the keypad scanner and the key-entry consumer.
package calc_pkg;
    localparam logic [4:0] PLUS  = 5'h10;
    localparam logic [4:0] MINUS = 5'h11;
    localparam logic [4:0] BACKS = 5'h12;
    localparam logic [4:0] ENTER = 5'h13;
    localparam logic [4:0] UP    = 5'h14;
    localparam logic [4:0] DOWN  = 5'h15;
    localparam logic [4:0] NOP   = 5'h16;

    function automatic logic is_digit(input logic [4:0] code);
        return code <= 5'd9;
    endfunction

    // Anything outside digits and PLUS..DOWN behaves like NOP.
    function automatic logic is_key(input logic [4:0] code);
        return is_digit(code) || (code >= PLUS && code <= DOWN);
    endfunction
endpackage

// File: rtl/key_debounce.sv
// Press/release debouncer: one accept strobe per physical key press.
module key_debounce
    import calc_pkg::*;
#(
    parameter int HOLD_CYCLES    = 4,
    parameter int RELEASE_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_intro,
    input  logic [4:0] i_value,
    output logic       o_accept,
    output logic [4:0] o_code
);
    localparam int CNT_MAX = (HOLD_CYCLES > RELEASE_CYCLES) ? HOLD_CYCLES : RELEASE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] ONE      = 1;
    localparam logic [CW-1:0] HOLD_END = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REL_END  = CW'(RELEASE_CYCLES - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONFIRM = 2'd1;
    localparam logic [1:0] S_HELD    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [4:0]    r_code;
    logic          w_match;

    assign w_match  = i_intro && (i_value == r_code);
    assign o_accept = (r_state == S_CONFIRM) && w_match && (r_cnt == HOLD_END);
    assign o_code   = r_code;

    // Reset lands in RELEASE so a key held through reset must be let go first.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_RELEASE;
            r_cnt   <= '0;
            r_code  <= NOP;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_intro && is_key(i_value)) begin
                        r_state <= S_CONFIRM;
                        r_code  <= i_value;
                        r_cnt   <= ONE;
                    end
                end
                S_CONFIRM: begin
                    if (!i_intro) begin
                        r_state <= S_IDLE;
                    end else if (i_value != r_code) begin
                        if (is_key(i_value)) begin
                            r_code <= i_value;
                            r_cnt  <= ONE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (r_cnt == HOLD_END) begin
                        r_state <= S_HELD;
                    end else begin
                        r_cnt <= r_cnt + ONE;
                    end
                end
                S_HELD: begin
                    if (!i_intro) begin
                        r_state <= S_RELEASE;
                        r_cnt   <= ONE;
                    end
                end
                S_RELEASE: begin
                    if (i_intro) begin
                        r_state <= S_HELD;
                    end else if (r_cnt == REL_END) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + ONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/key_entry.sv
// Key-entry consumer: debounced keys build a BCD operand and drive commit/op pulses.
module key_entry
    import calc_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int HOLD_CYCLES    = 4,
    parameter int RELEASE_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         intro,
    input  logic [4:0]                   value,
    output logic [4*DIGITS-1:0]          operand,
    output logic [$clog2(DIGITS+1)-1:0]  digit_count,
    output logic                         key_event,
    output logic [4:0]                   key_code,
    output logic                         entry_valid,
    output logic [4*DIGITS-1:0]          operand_out,
    output logic                         op_valid,
    output logic [4:0]                   op_code,
    output logic                         overflow
);
    localparam int OW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] ONE  = 1;
    localparam logic [CW-1:0] FULL = CW'(DIGITS);

    logic          w_accept;
    logic [4:0]    w_code;
    logic [OW-1:0] r_operand;
    logic [CW-1:0] r_count;
    logic          r_key_event;
    logic [4:0]    r_key_code;
    logic          r_entry_valid;
    logic [OW-1:0] r_operand_out;
    logic          r_op_valid;
    logic [4:0]    r_op_code;
    logic          r_overflow;

    key_debounce #(
        .HOLD_CYCLES    (HOLD_CYCLES),
        .RELEASE_CYCLES (RELEASE_CYCLES)
    ) u_debounce (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_intro  (intro),
        .i_value  (value),
        .o_accept (w_accept),
        .o_code   (w_code)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_operand     <= '0;
            r_count       <= '0;
            r_key_event   <= 1'b0;
            r_key_code    <= '0;
            r_entry_valid <= 1'b0;
            r_operand_out <= '0;
            r_op_valid    <= 1'b0;
            r_op_code     <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_key_event   <= w_accept;
            r_entry_valid <= 1'b0;
            r_op_valid    <= 1'b0;
            r_overflow    <= 1'b0;
            if (w_accept) begin
                r_key_code <= w_code;
                if (is_digit(w_code)) begin
                    // The cast keeps the low OW bits, dropping the oldest digit slot.
                    if (r_count < FULL) begin
                        r_operand <= OW'({r_operand, w_code[3:0]});
                        r_count   <= r_count + ONE;
                    end else begin
                        r_overflow <= 1'b1;
                    end
                end else begin
                    case (w_code)
                        BACKS: begin
                            r_operand <= r_operand >> 4;
                            if (r_count != '0) r_count <= r_count - ONE;
                        end
                        ENTER: begin
                            r_entry_valid <= 1'b1;
                            r_operand_out <= r_operand;
                            r_operand     <= '0;
                            r_count       <= '0;
                        end
                        PLUS, MINUS: begin
                            r_entry_valid <= 1'b1;
                            r_op_valid    <= 1'b1;
                            r_op_code     <= w_code;
                            r_operand_out <= r_operand;
                            r_operand     <= '0;
                            r_count       <= '0;
                        end
                        UP, DOWN: begin
                            r_op_valid <= 1'b1;
                            r_op_code  <= w_code;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign operand     = r_operand;
    assign digit_count = r_count;
    assign key_event   = r_key_event;
    assign key_code    = r_key_code;
    assign entry_valid = r_entry_valid;
    assign operand_out = r_operand_out;
    assign op_valid    = r_op_valid;
    assign op_code     = r_op_code;
    assign overflow    = r_overflow;
endmodule

// File: tb/tb_key_entry.sv
// Bench for key_entry: directed test-plan steps plus random presses, checked every cycle.
module tb_key_entry;
    import calc_pkg::*;

    localparam int DIGITS = 4;
    localparam int HOLD   = 4;
    localparam int REL    = 4;
    localparam int CW     = $clog2(DIGITS + 1);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                intro = 1'b0;
    logic [4:0]          value = NOP;
    logic [4*DIGITS-1:0] operand;
    logic [CW-1:0]       digit_count;
    logic                key_event;
    logic [4:0]          key_code;
    logic                entry_valid;
    logic [4*DIGITS-1:0] operand_out;
    logic                op_valid;
    logic [4:0]          op_code;
    logic                overflow;

    key_entry #(.DIGITS(DIGITS), .HOLD_CYCLES(HOLD), .RELEASE_CYCLES(REL)) dut (
        .clk         (clk),
        .rst         (rst),
        .intro       (intro),
        .value       (value),
        .operand     (operand),
        .digit_count (digit_count),
        .key_event   (key_event),
        .key_code    (key_code),
        .entry_valid (entry_valid),
        .operand_out (operand_out),
        .op_valid    (op_valid),
        .op_code     (op_code),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: digits as a queue, debounce as run lengths of samples.
    int   dq[$];
    int   m_out, m_opc, m_code;
    bit   m_ev, m_entry, m_opv, m_ovf;
    bit   armed;
    int   run, low;
    int   prev;

    function automatic int q_val();
        int v = 0;
        foreach (dq[i]) v = v * 16 + dq[i];
        return v;
    endfunction

    function automatic bit valid_code(input int c);
        return (c <= 9) || (c >= 'h10 && c <= 'h15);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("key_event",   32'(key_event),   32'(m_ev));
        chk("key_code",    32'(key_code),    32'(m_code));
        chk("operand",     32'(operand),     32'(q_val()));
        chk("digit_count", 32'(digit_count), 32'(dq.size()));
        chk("entry_valid", 32'(entry_valid), 32'(m_entry));
        chk("operand_out", 32'(operand_out), 32'(m_out));
        chk("op_valid",    32'(op_valid),    32'(m_opv));
        chk("op_code",     32'(op_code),     32'(m_opc));
        chk("overflow",    32'(overflow),    32'(m_ovf));
    endtask

    task automatic model_reset();
        dq.delete();
        m_out = 0; m_opc = 0; m_code = 0;
        m_ev = 0; m_entry = 0; m_opv = 0; m_ovf = 0;
        armed = 0; run = 0; low = 0; prev = NOP;
    endtask

    task automatic model_accept(input int c);
        m_ev = 1;
        m_code = c;
        if (c <= 9) begin
            if (dq.size() < DIGITS) dq.push_back(c);
            else m_ovf = 1;
        end else if (c == BACKS) begin
            if (dq.size() > 0) void'(dq.pop_back());
        end else if (c == ENTER || c == PLUS || c == MINUS) begin
            m_entry = 1;
            m_out = q_val();
            dq.delete();
            if (c != ENTER) begin m_opv = 1; m_opc = c; end
        end else begin
            m_opv = 1;
            m_opc = c;
        end
    endtask

    task automatic model_edge(input bit i, input int v);
        m_ev = 0; m_entry = 0; m_opv = 0; m_ovf = 0;
        if (i && valid_code(v)) run = (run > 0 && v == prev) ? run + 1 : 1;
        else run = 0;
        prev = v;
        if (i) low = 0;
        else if (low < REL) low++;
        if (armed && run == HOLD) begin
            armed = 0;
            model_accept(v);
        end else if (!armed && low >= REL) begin
            armed = 1;
        end
    endtask

    task automatic step(input bit i, input int v);
        intro = i;
        value = 5'(v);
        @(posedge clk);
        model_edge(i, v);
        #1 check_all();
    endtask

    task automatic press(input int c, input int hold, input int gap);
        repeat (hold) step(1, c);
        repeat (gap) step(0, NOP);
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        model_reset();
        #1 check_all();
        @(posedge clk);
        #1 check_all();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int c, r, hold, gap;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all();
        rst = 1'b0;
        repeat (REL) step(0, NOP);

        // Digits 1,2,3 then ENTER.
        press(1, 6, 6);
        press(2, 6, 6);
        press(3, 6, 6);
        chk("t1_operand", 32'(operand), 32'h0123);
        press(ENTER, 6, 6);
        chk("t1_commit", 32'(operand_out), 32'h0123);

        // Fill to capacity, then overflow.
        press(5, 6, 6); press(6, 6, 6); press(7, 6, 6); press(8, 6, 6);
        repeat (HOLD) step(1, 9);
        chk("t2_overflow", 32'(overflow), 32'h1);
        chk("t2_operand", 32'(operand), 32'h5678);
        repeat (6) step(0, NOP);
        press(ENTER, 6, 6);

        // Backspace down past empty.
        press(4, 6, 6); press(2, 6, 6);
        press(BACKS, 6, 6); press(BACKS, 6, 6);
        repeat (HOLD) step(1, BACKS);
        chk("t3_backs_empty_event", 32'(key_event), 32'h1);
        chk("t3_backs_empty_count", 32'(digit_count), 32'h0);
        repeat (6) step(0, NOP);

        // Bounce during confirm, then a dropout while held.
        repeat (3) step(1, 7);
        step(0, NOP);
        repeat (3) step(1, 7);
        step(0, NOP);
        repeat (4) step(1, 7);
        chk("t4_event", 32'(key_code), 32'h7);
        step(0, 7);
        repeat (3) step(1, 7);
        repeat (6) step(0, NOP);

        // Value change mid-confirm restarts the count.
        repeat (2) step(1, 2);
        repeat (4) step(1, 3);
        chk("t5_code", 32'(key_code), 32'h3);
        repeat (6) step(0, NOP);

        // Commit via PLUS, then reset while 8 is held.
        press(9, 6, 6);
        press(PLUS, 6, 6);
        repeat (3) step(1, 8);
        async_reset();
        repeat (6) step(1, 8);
        repeat (REL) step(0, NOP);
        press(8, 6, 6);

        // Random presses including bounces, dropouts and dead codes.
        for (int p = 0; p < 60; p++) begin
            r = $urandom_range(0, 9);
            if (r < 5)      c = $urandom_range(0, 9);
            else if (r < 9) c = 'h10 + $urandom_range(0, 5);
            else            c = ($urandom_range(0, 1) == 0) ? $urandom_range(10, 15) : $urandom_range('h16, 'h1f);
            hold = $urandom_range(1, 8);
            gap  = $urandom_range(1, 6);
            for (int h = 0; h < hold; h++) begin
                if ($urandom_range(0, 9) == 0) step(0, c);
                else if ($urandom_range(0, 11) == 0) step(1, $urandom_range(0, 31));
                else step(1, c);
            end
            repeat (gap) step(0, NOP);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
